// File: rtl/multi_accumulator.sv
// Multi-channel memory-mapped accumulator: per-channel 32-bit sum, saturating
// sample count, wrap/saturate in unsigned/signed arithmetic, sticky overflow.
module multi_accumulator #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int AW  = $clog2(NCH) + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          irq
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CHW-1:0] ch_s;
  logic [1:0]     off_s;

  logic [31:0]    sum_r   [NCH];
  logic [CW-1:0]  count_r [NCH];
  logic [NCH-1:0] ovf_r;
  logic [NCH-1:0] sat_r;
  logic [NCH-1:0] sgn_r;
  logic [31:0]    rdata_r;
  logic           irq_r;

  logic [31:0]    cur_sum_s;
  logic [CW-1:0]  cur_cnt_s;
  logic [32:0]    add_s;
  logic           ovf_s;
  logic [31:0]    sum_next_s;
  logic [CW-1:0]  cnt_next_s;
  logic           ctrl_wr_s;
  logic           acc_wr_s;
  logic [31:0]    rdata_s;

  // A single-channel build has no channel field in the address.
  generate
    if (NCH > 1) begin : g_multi
      assign ch_s = addr[AW-1:2];
    end else begin : g_single
      assign ch_s = 1'b0;
    end
  endgenerate

  assign off_s     = addr[1:0];
  assign cur_sum_s = sum_r[ch_s];
  assign cur_cnt_s = count_r[ch_s];
  assign add_s     = {1'b0, cur_sum_s} + {1'b0, wdata};
  assign ctrl_wr_s = ce & we & (off_s == 2'd0);
  assign acc_wr_s  = ce & we & (off_s == 2'd1);
  assign rdata     = rdata_r;
  assign irq       = irq_r;

  // Overflow detection and next sum/count for the addressed channel.
  always_comb begin
    ovf_s      = 1'b0;
    sum_next_s = add_s[31:0];
    cnt_next_s = cur_cnt_s;
    if (sgn_r[ch_s]) begin
      ovf_s = (cur_sum_s[31] == wdata[31]) && (add_s[31] != wdata[31]);
    end else begin
      ovf_s = add_s[32];
    end
    if (sat_r[ch_s] && ovf_s) begin
      if (sgn_r[ch_s]) begin
        sum_next_s = wdata[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        sum_next_s = 32'hFFFF_FFFF;
      end
    end else begin
      sum_next_s = add_s[31:0];
    end
    // Count sticks at all-ones rather than wrapping.
    if (&cur_cnt_s) begin
      cnt_next_s = cur_cnt_s;
    end else begin
      cnt_next_s = cur_cnt_s + CW'(1);
    end
  end

  // Read mux; CTRL is visible only on a pure read, ACC always reads zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (ce) begin
      case (off_s)
        2'd0: begin
          if (!we) begin
            rdata_s = {28'h000_0000, ovf_r[ch_s], sgn_r[ch_s], sat_r[ch_s], 1'b0};
          end else begin
            rdata_s = 32'h0000_0000;
          end
        end
        2'd2:    rdata_s = cur_sum_s;
        2'd3:    rdata_s = 32'(cur_cnt_s);
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Channel state, read data and interrupt registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        sum_r[i]   <= 32'h0000_0000;
        count_r[i] <= {CW{1'b0}};
      end
      ovf_r   <= {NCH{1'b0}};
      sat_r   <= {NCH{1'b0}};
      sgn_r   <= {NCH{1'b0}};
      rdata_r <= 32'h0000_0000;
      irq_r   <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        sat_r[ch_s] <= wdata[1];
        sgn_r[ch_s] <= wdata[2];
        if (wdata[0]) begin
          sum_r[ch_s]   <= 32'h0000_0000;
          count_r[ch_s] <= {CW{1'b0}};
          ovf_r[ch_s]   <= 1'b0;
        end
      end else if (acc_wr_s) begin
        sum_r[ch_s]   <= sum_next_s;
        count_r[ch_s] <= cnt_next_s;
        ovf_r[ch_s]   <= ovf_r[ch_s] | ovf_s;
      end
      rdata_r <= rdata_s;
      irq_r   <= |ovf_r;
    end
  end

endmodule
